// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: default constants, fetch FSM encoding and
// PC helper functions used across the IF stage.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_BOOT = 2'd0,
        F_RUN  = 2'd1,
        F_WAIT = 2'd2,
        F_KILL = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // PC arithmetic is modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0 silently.
    function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetch response that arrives while the IF stage
// is stalled; the entry is always drained before any newer response.
module fetch_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_instr,
    output logic              full,
    output logic [DATA_W-1:0] pop_addr,
    output logic [DATA_W-1:0] pop_instr
);

    logic [2*DATA_W-1:0] entry_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // Payload carries no reset; the full flag alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q <= {push_addr, push_instr};
        end
    end

    assign {pop_addr, pop_instr} = entry_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues word fetches to a wait-stated synchronous
// instruction memory and presents {pc_out, RI, PCPlus4} to the IF/ID register.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] RI,
    output logic [31:0] PCPlus4,
    output logic        fetch_valid,
    output logic        fetch_flush,
    output logic        misalign_err
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [31:0] pc_q;
    logic [31:0] wait_addr_p0;
    logic        kill_pend_q;
    logic        accept;

    logic        vld_p1;
    logic [31:0] addr_p1;
    logic        capture;

    logic        skid_full;
    logic        skid_push;
    logic        skid_pop;
    logic [31:0] skid_addr;
    logic [31:0] skid_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Request stays raised with a frozen address in WAIT until the memory
    // accepts it; a redirect seen meanwhile turns that accept into a squash.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            F_BOOT: state_d = F_RUN;
            F_RUN: begin
                imem_req = !StallF && !skid_full && !RedirectE;
                if (imem_req && !imem_ready) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = wait_addr_p0;
                if (imem_ready) begin
                    state_d = (RedirectE || kill_pend_q) ? F_KILL : F_RUN;
                end
            end
            F_KILL:  state_d = F_RUN;
            default: state_d = F_BOOT;
        endcase
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    assign accept       = imem_req && imem_ready;
    assign fetch_flush  = RedirectE && !reset;
    assign misalign_err = RedirectE && !reset && (RedirectTargetE[1:0] != 2'b00);

    // ---- stage p0: PC and request address ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            kill_pend_q <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            if (RedirectE) begin
                pc_q <= word_align(RedirectTargetE);
            end else if (accept && !kill_pend_q) begin
                pc_q <= pc_add(pc_q, 32'd4);
            end
            kill_pend_q <= (state_q == F_WAIT) && !imem_ready && (kill_pend_q || RedirectE);
            vld_p1      <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == F_RUN && imem_req && !imem_ready) begin
            wait_addr_p0 <= pc_q;
        end
        if (accept) begin
            addr_p1 <= imem_addr;
        end
    end

    // ---- stage p1: response arrival, squash and skid ----
    assign capture   = imem_rvalid && vld_p1 && (state_q != F_KILL) && !RedirectE;
    assign skid_pop  = skid_full && !StallF && !RedirectE;
    assign skid_push = capture && (StallF || skid_full);

    fetch_skid_buffer #(
        .DATA_W (32)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (RedirectE),
        .push_addr  (addr_p1),
        .push_instr (imem_rdata),
        .full       (skid_full),
        .pop_addr   (skid_addr),
        .pop_instr  (skid_instr)
    );

    // ---- stage p2: IF/ID-facing output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out      <= 32'h0;
            PCPlus4     <= 32'h0;
            RI          <= NOP_INSTR;
            fetch_valid <= 1'b0;
        end else if (RedirectE) begin
            RI          <= NOP_INSTR;
            fetch_valid <= 1'b0;
        end else if (!StallF) begin
            if (skid_pop) begin
                RI          <= skid_instr;
                pc_out      <= pc_add(skid_addr, 32'd4);
                PCPlus4     <= pc_add(skid_addr, 32'd8);
                fetch_valid <= 1'b1;
            end else if (capture) begin
                RI          <= imem_rdata;
                pc_out      <= pc_add(addr_p1, 32'd4);
                PCPlus4     <= pc_add(addr_p1, 32'd8);
                fetch_valid <= 1'b1;
            end else begin
                RI          <= NOP_INSTR;
                fetch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed per-cycle vector table, a reset
// corner sequence, and randomized traffic against a program-order scoreboard.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        RedirectE;
    logic [31:0] RedirectTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] RI;
    logic [31:0] PCPlus4;
    logic        fetch_valid;
    logic        fetch_flush;
    logic        misalign_err;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .StallF          (StallF),
        .RedirectE       (RedirectE),
        .RedirectTargetE (RedirectTargetE),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .RI              (RI),
        .PCPlus4         (PCPlus4),
        .fetch_valid     (fetch_valid),
        .fetch_flush     (fetch_flush),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model state and per-cycle samples of combinational outputs
    logic        mem_pend = 1'b0;
    logic [31:0] mem_pend_addr = 32'h0;
    logic        inj_rvalid = 1'b0;
    logic        s_req, s_flush, s_mis;
    logic [31:0] s_addr;

    // scoreboard state for the random phase
    logic [31:0] exp_fetch, exp_deliv, prev_addr;
    logic        stale, prev_pend;
    logic        snap_valid;
    logic [31:0] snap_ri, snap_pc, snap_p4;
    int          delivered;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tg;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_flush;
        logic        e_mis;
        logic        e_valid;
        logic [31:0] e_ri;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] tg, input logic rdy,
                       input logic req, input logic [31:0] addr, input logic fl, input logic mi,
                       input logic v, input logic [31:0] ri, input logic [31:0] pc);
        vec_t e;
        e.st = st; e.rd = rd; e.tg = tg; e.rdy = rdy;
        e.e_req = req; e.e_addr = addr; e.e_flush = fl; e.e_mis = mi;
        e.e_valid = v; e.e_ri = ri; e.e_pc = pc;
        vecs.push_back(e);
    endtask

    // One clock: drive at negedge, sample combinational outputs, then let the
    // memory model register any accept and return just after the posedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tg, input logic rdy);
        @(negedge clk);
        StallF          = st;
        RedirectE       = rd;
        RedirectTargetE = tg;
        imem_ready      = rdy;
        imem_rvalid     = mem_pend | inj_rvalid;
        imem_rdata      = mem_pend ? mem_word(mem_pend_addr) : 32'hBAD0_BAD0;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_flush = fetch_flush;
        s_mis   = misalign_err;
        @(posedge clk);
        mem_pend      = s_req & rdy;
        mem_pend_addr = s_addr;
        inj_rvalid    = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, ".pc_out"}, pc_out, 32'h0);
        check32({tag, ".PCPlus4"}, PCPlus4, 32'h0);
        check32({tag, ".RI"}, RI, NOP);
        check1({tag, ".valid"}, fetch_valid, 1'b0);
    endtask

    task automatic snapshot();
        snap_valid = fetch_valid;
        snap_ri    = RI;
        snap_pc    = pc_out;
        snap_p4    = PCPlus4;
    endtask

    // Random-phase cycle: fetch addresses must follow program order (restarting
    // at each aligned redirect target), deliveries must be consecutive words
    // with matching memory contents, and a stall freezes every output.
    task automatic rcycle(input logic st, input logic rd, input logic [31:0] tg, input logic rdy);
        logic acc;
        cycle(st, rd, tg, rdy);
        acc = s_req & rdy;
        check1("r.flush", s_flush, rd);
        check1("r.misalign", s_mis, rd && (tg[1:0] != 2'b00));
        if (prev_pend) begin
            check1("r.hold_req", s_req, 1'b1);
            check32("r.hold_addr", s_addr, prev_addr);
        end
        if (acc && st) check1("r.accept_in_stall_was_pending", prev_pend, 1'b1);
        if (acc) begin
            if (stale || rd) begin
                stale = 1'b0;
            end else begin
                check32("r.fetch_addr", s_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        if (rd) begin
            exp_fetch = tg & 32'hFFFF_FFFC;
            if (s_req && !acc) stale = 1'b1;
        end
        prev_pend = s_req & !rdy;
        prev_addr = s_addr;

        if (rd) begin
            check1("r.redirect_valid", fetch_valid, 1'b0);
            check32("r.redirect_RI", RI, NOP);
            exp_deliv = tg & 32'hFFFF_FFFC;
        end else if (st) begin
            check1("r.stall_valid", fetch_valid, snap_valid);
            check32("r.stall_RI", RI, snap_ri);
            check32("r.stall_pc", pc_out, snap_pc);
            check32("r.stall_p4", PCPlus4, snap_p4);
        end else if (fetch_valid) begin
            check32("r.pc_out", pc_out, exp_deliv + 32'd4);
            check32("r.RI", RI, mem_word(exp_deliv));
            check32("r.PCPlus4", PCPlus4, exp_deliv + 32'd8);
            exp_deliv = exp_deliv + 32'd4;
            delivered++;
        end else begin
            check32("r.bubble_RI", RI, NOP);
        end
        snapshot();
    endtask

    initial begin
        logic        st_r, rd_r, rdy_r;
        logic [31:0] tg_r;
        int          d0;

        reset = 1'b1; StallF = 1'b0; RedirectE = 1'b0; RedirectTargetE = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // stall, redirect, target, ready | req, addr, flush, mis | valid, RI, pc_out
        add(0, 0, 32'h0, 1,   0, 32'h0,   0, 0,   0, NOP,   32'h0);    // BOOT
        add(0, 0, 32'h0, 1,   1, 32'h0,   0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h4,   0, 0,   1, 32'h0, 32'h4);
        add(0, 0, 32'h0, 0,   1, 32'h8,   0, 0,   1, 32'h1, 32'h8);    // wait states on 0x8
        add(0, 0, 32'h0, 0,   1, 32'h8,   0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 0,   1, 32'h8,   0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h8,   0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'hC,   0, 0,   1, 32'h2, 32'hC);
        add(1, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h2, 32'hC);    // stall, 0xC to skid
        add(1, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h2, 32'hC);
        add(1, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h2, 32'hC);
        add(1, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h2, 32'hC);
        add(0, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h3, 32'h10);   // skid drains first
        add(0, 0, 32'h0, 1,   1, 32'h10,  0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h14,  0, 0,   1, 32'h4, 32'h14);
        add(0, 1, 32'h100, 1, 0, 32'h0,   1, 0,   0, NOP,   32'h0);    // redirect, 0x14 squashed
        add(0, 0, 32'h0, 1,   1, 32'h100, 0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h104, 0, 0,   1, 32'h40, 32'h104);
        add(1, 0, 32'h0, 1,   0, 32'h0,   0, 0,   1, 32'h40, 32'h104);
        add(1, 1, 32'h202, 1, 0, 32'h0,   1, 1,   0, NOP,   32'h0);    // stall+misaligned redirect
        add(0, 0, 32'h0, 1,   1, 32'h200, 0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h204, 0, 0,   1, 32'h80, 32'h204);
        add(0, 0, 32'h0, 1,   1, 32'h208, 0, 0,   1, 32'h81, 32'h208);
        add(0, 0, 32'h0, 0,   1, 32'h20C, 0, 0,   1, 32'h82, 32'h20C);
        add(0, 1, 32'h300, 0, 1, 32'h20C, 1, 0,   0, NOP,   32'h0);    // redirect while waiting
        add(0, 0, 32'h0, 1,   1, 32'h20C, 0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   0, 32'h0,   0, 0,   0, NOP,   32'h0);    // squashed response
        add(0, 0, 32'h0, 1,   1, 32'h300, 0, 0,   0, NOP,   32'h0);
        add(0, 0, 32'h0, 1,   1, 32'h304, 0, 0,   1, 32'hC0, 32'h304);
        add(0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0, 1, 0, 0, NOP, 32'h0);
        add(0, 0, 32'h0, 1,   1, 32'hFFFF_FFF8, 0, 0, 0, NOP, 32'h0);
        add(0, 0, 32'h0, 1,   1, 32'hFFFF_FFFC, 0, 0, 1, 32'h3FFF_FFFE, 32'hFFFF_FFFC);
        add(0, 0, 32'h0, 1,   1, 32'h0,   0, 0,   1, 32'h3FFF_FFFF, 32'h0);   // PC wraps
        add(0, 0, 32'h0, 1,   1, 32'h4,   0, 0,   1, 32'h0, 32'h4);

        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        check1("reset.req", s_req, 1'b0);
        check1("reset.flush", s_flush, 1'b0);
        check_reset_outputs("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].st, vecs[i].rd, vecs[i].tg, vecs[i].rdy);
            check1($sformatf("v%0d.req", i), s_req, vecs[i].e_req);
            if (vecs[i].e_req) check32($sformatf("v%0d.addr", i), s_addr, vecs[i].e_addr);
            check1($sformatf("v%0d.flush", i), s_flush, vecs[i].e_flush);
            check1($sformatf("v%0d.misalign", i), s_mis, vecs[i].e_mis);
            check1($sformatf("v%0d.valid", i), fetch_valid, vecs[i].e_valid);
            check32($sformatf("v%0d.RI", i), RI, vecs[i].e_ri);
            if (vecs[i].e_valid) begin
                check32($sformatf("v%0d.pc_out", i), pc_out, vecs[i].e_pc);
                check32($sformatf("v%0d.PCPlus4", i), PCPlus4, vecs[i].e_pc + 32'd4);
            end
        end

        // reset while a request is held in WAIT, followed by a stray rvalid
        cycle(0, 0, 32'h0, 0);
        check1("t6.wait_req", s_req, 1'b1);
        check32("t6.wait_addr", s_addr, 32'h8);
        reset = 1'b1;
        cycle(0, 0, 32'h0, 1);
        check1("t6.reset_req", s_req, 1'b0);
        check_reset_outputs("t6");
        reset = 1'b0;
        inj_rvalid = 1'b1;
        cycle(0, 0, 32'h0, 1);
        check1("t6.boot_req", s_req, 1'b0);
        check1("t6.late_valid", fetch_valid, 1'b0);
        check32("t6.late_RI", RI, NOP);
        cycle(0, 0, 32'h0, 1);
        check1("t6.refetch_req", s_req, 1'b1);
        check32("t6.refetch_addr", s_addr, 32'h0);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        check1("t6.first_valid", fetch_valid, 1'b1);
        check32("t6.first_RI", RI, 32'h1);
        check32("t6.first_pc", pc_out, 32'h8);

        // randomized traffic
        reset = 1'b1;
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        reset = 1'b0;
        exp_fetch = 32'h0; exp_deliv = 32'h0; stale = 1'b0;
        prev_pend = 1'b0; prev_addr = 32'h0; delivered = 0;
        snapshot();
        for (int n = 0; n < 3000; n++) begin
            st_r  = ($urandom_range(0, 99) < 20);
            rd_r  = ($urandom_range(0, 99) < 4);
            rdy_r = ($urandom_range(0, 99) < 70);
            tg_r  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) tg_r[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) tg_r = tg_r | 32'hFFFF_F000;
            rcycle(st_r, rd_r, tg_r, rdy_r);
        end
        d0 = delivered;
        for (int n = 0; n < 12; n++) begin
            rcycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check1("r.progress", (delivered - d0) >= 8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
